avalon_burst_master: RTL and testbench

AVALON_BURST_MASTER -- requirements
Module: avalon_burst_master

---
 rtl/avalon_burst_master.sv | 168 ++++++++++++++++
 tb/tb_avalon_burst_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_master.sv
// Avalon-MM burst master: turns one user command into a single write or read burst.
// Optional read timeout enabled by defining AVL_MASTER_TIMEOUT_EN.
module avalon_burst_master #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int BURST_W     = 10,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               avl_clk,
  input  logic               avl_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_address,
  input  logic [BURST_W-1:0] cmd_burstcount,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  avl_address,
  output logic               avl_read,
  output logic               avl_write,
  output logic [DATA_W-1:0]  avl_writedata,
  output logic [BURST_W-1:0] avl_burstcount,
  output logic               avl_beginbursttransfer,
  input  logic               avl_waitrequest,
  input  logic [DATA_W-1:0]  avl_readdata,
  input  logic               avl_readdatavalid
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_REQ, RD_DATA} state_t;

  localparam logic [BURST_W:0]   CNT_ONE   = 1;
  localparam logic [BURST_W-1:0] BURST_ONE = 1;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [BURST_W:0]     cnt_q, cnt_d, cnt_inc;
  logic                 bbt_q, bbt_d;
  logic                 done_q, done_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 cmd_fire, wr_beat, rd_beat, last_beat;

`ifdef AVL_MASTER_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            error_q, error_d;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Holding off cmd_ready during the done pulse keeps back-to-back commands a cycle apart.
  assign cmd_ready     = (state_q == IDLE) && !done_q;
  assign cmd_fire      = cmd_valid && cmd_ready;
  assign avl_write     = (state_q == WR_BURST) && wr_valid;
  assign avl_writedata = (state_q == WR_BURST) ? wr_data : '0;
  assign wr_ready      = (state_q == WR_BURST) && !avl_waitrequest;
  assign avl_read      = (state_q == RD_REQ);
  assign wr_beat       = avl_write && !avl_waitrequest;
  assign rd_beat       = avl_readdatavalid && ((state_q == RD_REQ) || (state_q == RD_DATA));
  assign cnt_inc       = cnt_q + CNT_ONE;
  assign last_beat     = (cnt_inc == {1'b0, burst_q});

  assign avl_address            = addr_q;
  assign avl_burstcount         = burst_q;
  assign avl_beginbursttransfer = bbt_q;
  assign rd_data                = rd_data_q;
  assign rd_valid               = rd_valid_q;
  assign done                   = done_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    bbt_d      = 1'b0;
    done_d     = 1'b0;
    rd_data_d  = avl_readdata;
    rd_valid_d = rd_beat;
`ifdef AVL_MASTER_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    error_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          addr_d  = cmd_address;
          burst_d = (cmd_burstcount == '0) ? BURST_ONE : cmd_burstcount;
          cnt_d   = '0;
          bbt_d   = 1'b1;
          state_d = cmd_write ? WR_BURST : RD_REQ;
        end
      end
      WR_BURST: begin
        if (wr_beat) begin
          cnt_d = cnt_inc;
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RD_REQ, RD_DATA: begin
        if ((state_q == RD_REQ) && !avl_waitrequest) state_d = RD_DATA;
        // A beat may arrive in the same cycle the read command is accepted.
        if (rd_beat) begin
          cnt_d = cnt_inc;
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AVL_MASTER_TIMEOUT_EN
    // Counter idles at zero outside RD_DATA, so entering RD_DATA starts a fresh count.
    if ((state_q != RD_DATA) || rd_beat) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d = '0;
      state_d  = IDLE;
      error_d  = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end
`endif
  end

  always_ff @(posedge avl_clk) begin
    if (avl_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      bbt_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef AVL_MASTER_TIMEOUT_EN
      to_cnt_q   <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      bbt_q      <= bbt_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef AVL_MASTER_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      error_q    <= error_d;
`endif
    end
  end

endmodule

// File: tb/tb_avalon_burst_master.sv
// Directed self-checking bench for avalon_burst_master: write/read bursts, stalls,
// zero burstcount, stray read data, mid-burst reset and read timeout behaviour.
module tb_avalon_burst_master;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;
  localparam int BURST_W = 10;

  logic               avl_clk = 1'b0;
  logic               avl_rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_write = 1'b0;
  logic [ADDR_W-1:0]  cmd_address = '0;
  logic [BURST_W-1:0] cmd_burstcount = '0;
  logic [DATA_W-1:0]  wr_data = '0;
  logic               wr_valid = 1'b0;
  logic               wr_ready;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               done;
  logic               error;
  logic [ADDR_W-1:0]  avl_address;
  logic               avl_read;
  logic               avl_write;
  logic [DATA_W-1:0]  avl_writedata;
  logic [BURST_W-1:0] avl_burstcount;
  logic               avl_beginbursttransfer;
  logic               avl_waitrequest = 1'b0;
  logic [DATA_W-1:0]  avl_readdata = '0;
  logic               avl_readdatavalid = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 avl_clk = ~avl_clk;

  avalon_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .TIMEOUT_CYC(16)
  ) dut (
    .avl_clk(avl_clk), .avl_rst(avl_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_burstcount(cmd_burstcount),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .error(error),
    .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
    .avl_writedata(avl_writedata), .avl_burstcount(avl_burstcount),
    .avl_beginbursttransfer(avl_beginbursttransfer),
    .avl_waitrequest(avl_waitrequest), .avl_readdata(avl_readdata),
    .avl_readdatavalid(avl_readdatavalid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle;
    @(posedge avl_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic wq,
                               input logic rv, input logic [7:0] rdat);
    wr_valid          = wv;
    wr_data           = wd;
    avl_waitrequest   = wq;
    avl_readdatavalid = rv;
    avl_readdata      = rdat;
    #1;
  endtask

  task automatic issueCommand(input logic wr, input logic [9:0] addr, input logic [9:0] bc);
    cmd_valid      = 1'b1;
    cmd_write      = wr;
    cmd_address    = addr;
    cmd_burstcount = bc;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    nextCycle;
    cmd_valid = 1'b0;
  endtask

  // Write burst of 4 beats to 0x010; the master presents the next beat after each acceptance.
  task automatic runWrite(input string name, input int nCyc, input logic [15:0] wvBits,
                          input logic [15:0] wqBits);
    int beats = 0;
    issueCommand(1'b1, 10'h010, 10'd4);
    for (int c = 0; c < nCyc; c++) begin
      applyStimulus(wvBits[c], 8'hA0 + 8'(beats), wqBits[c], 1'b0, 8'h00);
      checkOutput({name, "_avl_write"}, 32'(avl_write), 32'(wvBits[c]));
      checkOutput({name, "_wdata"}, 32'(avl_writedata), 32'(8'hA0 + 8'(beats)));
      checkOutput({name, "_wr_ready"}, 32'(wr_ready), 32'(!wqBits[c]));
      checkOutput({name, "_bbt"}, 32'(avl_beginbursttransfer), 32'(c == 0));
      checkOutput({name, "_addr"}, 32'(avl_address), 32'h010);
      checkOutput({name, "_bc"}, 32'(avl_burstcount), 32'd4);
      checkOutput({name, "_done_mid"}, 32'(done), 32'd0);
      if (wvBits[c] && !wqBits[c]) beats++;
      nextCycle;
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput({name, "_done"}, 32'(done), 32'd1);
    checkOutput({name, "_write_after"}, 32'(avl_write), 32'd0);
    checkOutput({name, "_ready_in_done"}, 32'(cmd_ready), 32'd0);
    nextCycle;
    checkOutput({name, "_done_once"}, 32'(done), 32'd0);
    checkOutput({name, "_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  // Read burst; returned beats carry 0x11, 0x22, 0x33... in order.
  task automatic runRead(input string name, input logic [9:0] addr, input logic [9:0] bc,
                         input logic [9:0] expBc, input int nCyc, input logic [15:0] wqBits,
                         input logic [15:0] rvBits, input logic [15:0] expReadBits);
    int k = 0;
    logic prevV = 1'b0;
    logic [7:0] prevD = 8'h00;
    logic [7:0] dat;
    issueCommand(1'b0, addr, bc);
    for (int c = 0; c < nCyc; c++) begin
      dat = rvBits[c] ? 8'h11 * 8'(k + 1) : 8'hEE;
      applyStimulus(1'b0, 8'h00, wqBits[c], rvBits[c], dat);
      checkOutput({name, "_avl_read"}, 32'(avl_read), 32'(expReadBits[c]));
      checkOutput({name, "_bbt"}, 32'(avl_beginbursttransfer), 32'(c == 0));
      checkOutput({name, "_addr"}, 32'(avl_address), 32'(addr));
      checkOutput({name, "_bc"}, 32'(avl_burstcount), 32'(expBc));
      checkOutput({name, "_rd_valid"}, 32'(rd_valid), 32'(prevV));
      if (prevV) checkOutput({name, "_rd_data"}, 32'(rd_data), 32'(prevD));
      checkOutput({name, "_done_mid"}, 32'(done), 32'd0);
      prevV = rvBits[c];
      prevD = dat;
      if (rvBits[c]) k++;
      nextCycle;
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput({name, "_last_valid"}, 32'(rd_valid), 32'd1);
    checkOutput({name, "_last_data"}, 32'(rd_data), 32'(prevD));
    checkOutput({name, "_done"}, 32'(done), 32'd1);
    nextCycle;
    checkOutput({name, "_done_once"}, 32'(done), 32'd0);
    checkOutput({name, "_valid_after"}, 32'(rd_valid), 32'd0);
    checkOutput({name, "_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    nextCycle;
    nextCycle;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_avl_read", 32'(avl_read), 32'd0);
    checkOutput("rst_avl_write", 32'(avl_write), 32'd0);
    checkOutput("rst_bbt", 32'(avl_beginbursttransfer), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_addr", 32'(avl_address), 32'd0);
    checkOutput("rst_bc", 32'(avl_burstcount), 32'd0);
    checkOutput("rst_wdata", 32'(avl_writedata), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    avl_rst = 1'b0;
    nextCycle;
    checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);

    runWrite("wr_plain", 4, 16'b0000_0000_0000_1111, 16'b0);
    runWrite("wr_stall", 7, 16'b0000_0000_0110_1111, 16'b0000_0000_0000_0110);

    runRead("rd_gap", 10'h3FE, 10'd3, 10'd3, 7,
            16'b0000_0000_0000_0011, 16'b0000_0000_0110_1000, 16'b0000_0000_0000_0111);
    runRead("rd_zero", 10'h155, 10'd0, 10'd1, 2,
            16'b0, 16'b0000_0000_0000_0010, 16'b0000_0000_0000_0001);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A);
    checkOutput("stray_valid_now", 32'(rd_valid), 32'd0);
    nextCycle;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("stray_valid_next", 32'(rd_valid), 32'd0);
    nextCycle;

    // Reset lands after the second beat of an 8-beat write.
    issueCommand(1'b1, 10'h0AA, 10'd8);
    applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0, 8'h00);
    checkOutput("mrst_write_b0", 32'(avl_write), 32'd1);
    nextCycle;
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00);
    nextCycle;
    avl_rst = 1'b1;
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0, 8'h00);
    nextCycle;
    checkOutput("mrst_write", 32'(avl_write), 32'd0);
    checkOutput("mrst_read", 32'(avl_read), 32'd0);
    checkOutput("mrst_bbt", 32'(avl_beginbursttransfer), 32'd0);
    checkOutput("mrst_done", 32'(done), 32'd0);
    checkOutput("mrst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("mrst_addr", 32'(avl_address), 32'd0);
    checkOutput("mrst_bc", 32'(avl_burstcount), 32'd0);
    checkOutput("mrst_wdata", 32'(avl_writedata), 32'd0);
    avl_rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    nextCycle;
    checkOutput("mrst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mrst_done_after", 32'(done), 32'd0);
    nextCycle;
    checkOutput("mrst_done_later", 32'(done), 32'd0);

    // Read of 2 beats where the slave only ever returns one.
    issueCommand(1'b0, 10'h020, 10'd2);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("to_avl_read", 32'(avl_read), 32'd1);
    nextCycle;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h11);
    nextCycle;
    for (int c = 2; c < 26; c++) begin
`ifdef AVL_MASTER_TIMEOUT_EN
      applyStimulus(1'b0, 8'h00, 1'b0, (c == 20), 8'h77);
      checkOutput("to_error", 32'(error), 32'(c == 18));
      checkOutput("to_cmd_ready", 32'(cmd_ready), 32'(c >= 18));
      checkOutput("to_rd_valid", 32'(rd_valid), 32'(c == 2));
`else
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      checkOutput("to_error", 32'(error), 32'd0);
      checkOutput("to_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("to_rd_valid", 32'(rd_valid), 32'(c == 2));
`endif
      checkOutput("to_done", 32'(done), 32'd0);
      checkOutput("to_read_low", 32'(avl_read), 32'd0);
      nextCycle;
    end
    avl_rst = 1'b1;
    nextCycle;
    avl_rst = 1'b0;
    nextCycle;
    checkOutput("final_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
